// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcodes, instruction classes, ALU ops and immediate formats.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef enum logic [3:0] {
      CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_LOAD,
      CLS_STORE, CLS_OP_IMM, CLS_OP, CLS_MISC_MEM, CLS_SYSTEM, CLS_ILLEGAL
   } class_e;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
   } imm_fmt_e;

   // alt selects SUB over ADD and SRA over SRL; other funct3 values ignore it.
   function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/riscv_register_file.sv
// 2-read 1-write register file; x0 reads zero, same-cycle writes bypass to the read ports.
module riscv_register_file
   import riscv_pkg::*;
#(
   parameter int REG_COUNT = 32,
   parameter int AW        = $clog2(REG_COUNT)
) (
   input  logic            clock_i,
   input  logic            write_enable,
   input  logic [AW-1:0]   write_index,
   input  logic [XLEN-1:0] write_data,
   input  logic [AW-1:0]   read_index_a,
   input  logic [AW-1:0]   read_index_b,
   output logic [XLEN-1:0] read_data_a,
   output logic [XLEN-1:0] read_data_b
);

   logic [XLEN-1:0] regs [REG_COUNT];

   always_ff @(posedge clock_i) begin
      if (write_enable && write_index != '0)
         regs[write_index] <= write_data;
   end

   always_comb begin
      read_data_a = '0;
      if (read_index_a != '0)
         read_data_a = (write_enable && write_index == read_index_a) ? write_data : regs[read_index_a];
   end

   always_comb begin
      read_data_b = '0;
      if (read_index_b != '0)
         read_data_b = (write_enable && write_index == read_index_b) ? write_data : regs[read_index_b];
   end

endmodule

// File: rtl/riscv_decode_stage.sv
// RV32I decode stage: field/immediate/class decode plus operand read into one registered slot.
module riscv_decode_stage
   import riscv_pkg::*;
#(
   parameter int REG_COUNT = 32
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        fetch_valid_i,
   output logic        fetch_ready_o,
   input  logic [31:0] instruction_i,
   input  logic [31:0] instruction_address_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        writeback_enable_i,
   input  logic [4:0]  writeback_rd_i,
   input  logic [31:0] writeback_data_i,
   output logic        decode_valid_o,
   output logic [31:0] pc_o,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o,
   output logic [4:0]  rd_o,
   output logic [31:0] rs1_data_o,
   output logic [31:0] rs2_data_o,
   output logic [31:0] immediate_o,
   output logic [2:0]  funct3_o,
   output logic [3:0]  alu_op_o,
   output logic [3:0]  class_o,
   output logic        illegal_o
);

   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] rs1_data, rs2_data, imm;
   class_e      dec_class;
   alu_op_e     dec_alu;
   imm_fmt_e    fmt;
   logic        dec_illegal;
   logic        transfer;

   assign opcode = instruction_i[6:0];
   assign rd     = instruction_i[11:7];
   assign funct3 = instruction_i[14:12];
   assign rs1    = instruction_i[19:15];
   assign rs2    = instruction_i[24:20];
   assign funct7 = instruction_i[31:25];

   assign fetch_ready_o = !decode_valid_o || !stall_i;
   assign transfer      = fetch_valid_i && fetch_ready_o;

   riscv_register_file #(.REG_COUNT(REG_COUNT)) u_regfile (
      .clock_i      (clock_i),
      .write_enable (writeback_enable_i),
      .write_index  (writeback_rd_i),
      .write_data   (writeback_data_i),
      .read_index_a (rs1),
      .read_index_b (rs2),
      .read_data_a  (rs1_data),
      .read_data_b  (rs2_data)
   );

   always_comb begin
      dec_class   = CLS_ILLEGAL;
      dec_alu     = ALU_ADD;
      fmt         = IMM_NONE;
      dec_illegal = 1'b0;
      if (instruction_i[1:0] != 2'b11) begin
         dec_illegal = 1'b1;
      end else begin
         case (opcode)
            OPC_LUI:      begin dec_class = CLS_LUI;      fmt = IMM_U; end
            OPC_AUIPC:    begin dec_class = CLS_AUIPC;    fmt = IMM_U; end
            OPC_JAL:      begin dec_class = CLS_JAL;      fmt = IMM_J; end
            OPC_JALR:     begin dec_class = CLS_JALR;     fmt = IMM_I; end
            OPC_BRANCH:   begin dec_class = CLS_BRANCH;   fmt = IMM_B; end
            OPC_LOAD:     begin dec_class = CLS_LOAD;     fmt = IMM_I; end
            OPC_STORE:    begin dec_class = CLS_STORE;    fmt = IMM_S; end
            OPC_MISC_MEM: begin dec_class = CLS_MISC_MEM; fmt = IMM_I; end
            OPC_SYSTEM:   begin dec_class = CLS_SYSTEM;   fmt = IMM_I; end
            OPC_OP_IMM: begin
               dec_class = CLS_OP_IMM;
               fmt       = IMM_I;
               // Bit 30 is part of the immediate for ADDI; only shifts treat it as alt.
               dec_alu   = alu_from_funct3(funct3, instruction_i[30] && funct3 == 3'b101);
            end
            OPC_OP: begin
               dec_class = CLS_OP;
               dec_alu   = alu_from_funct3(funct3, funct7[5]);
               if (!(funct7 == 7'b0000000 ||
                     (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
                  dec_illegal = 1'b1;
            end
            default: dec_illegal = 1'b1;
         endcase
      end
   end

   always_comb begin
      case (fmt)
         IMM_I:   imm = {{20{instruction_i[31]}}, instruction_i[31:20]};
         IMM_S:   imm = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
         IMM_B:   imm = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                         instruction_i[30:25], instruction_i[11:8], 1'b0};
         IMM_U:   imm = {instruction_i[31:12], 12'b0};
         IMM_J:   imm = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                         instruction_i[20], instruction_i[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         decode_valid_o <= 1'b0;
         pc_o           <= '0;
         rs1_o          <= '0;
         rs2_o          <= '0;
         rd_o           <= '0;
         rs1_data_o     <= '0;
         rs2_data_o     <= '0;
         immediate_o    <= '0;
         funct3_o       <= '0;
         alu_op_o       <= '0;
         class_o        <= '0;
         illegal_o      <= 1'b0;
      end else if (flush_i) begin
         decode_valid_o <= 1'b0;
      end else if (transfer) begin
         decode_valid_o <= 1'b1;
         pc_o           <= instruction_address_i;
         rs1_o          <= rs1;
         rs2_o          <= rs2;
         rd_o           <= rd;
         rs1_data_o     <= rs1_data;
         rs2_data_o     <= rs2_data;
         immediate_o    <= imm;
         funct3_o       <= funct3;
         alu_op_o       <= dec_alu;
         class_o        <= dec_class;
         illegal_o      <= dec_illegal;
      end else if (!stall_i) begin
         decode_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed bench for riscv_decode_stage with hand-computed expectations.
module tb_riscv_decode_stage;
   import riscv_pkg::*;

   logic        clock_i = 1'b0;
   logic        reset_i, fetch_valid_i, fetch_ready_o, stall_i, flush_i;
   logic [31:0] instruction_i, instruction_address_i;
   logic        writeback_enable_i;
   logic [4:0]  writeback_rd_i;
   logic [31:0] writeback_data_i;
   logic        decode_valid_o, illegal_o;
   logic [31:0] pc_o, rs1_data_o, rs2_data_o, immediate_o;
   logic [4:0]  rs1_o, rs2_o, rd_o;
   logic [2:0]  funct3_o;
   logic [3:0]  alu_op_o, class_o;

   int checks = 0;
   int errors = 0;

   riscv_decode_stage dut (
      .clock_i(clock_i), .reset_i(reset_i),
      .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
      .instruction_i(instruction_i), .instruction_address_i(instruction_address_i),
      .stall_i(stall_i), .flush_i(flush_i),
      .writeback_enable_i(writeback_enable_i), .writeback_rd_i(writeback_rd_i),
      .writeback_data_i(writeback_data_i),
      .decode_valid_o(decode_valid_o), .pc_o(pc_o),
      .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
      .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
      .immediate_o(immediate_o), .funct3_o(funct3_o),
      .alu_op_o(alu_op_o), .class_o(class_o), .illegal_o(illegal_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present inputs, take one edge, settle past it.
   task automatic step();
      @(posedge clock_i);
      #1;
   endtask

   task automatic fetch(input logic [31:0] word, input logic [31:0] pc);
      fetch_valid_i         = 1'b1;
      instruction_i         = word;
      instruction_address_i = pc;
   endtask

   task automatic idle();
      fetch_valid_i      = 1'b0;
      stall_i            = 1'b0;
      flush_i            = 1'b0;
      writeback_enable_i = 1'b0;
      reset_i            = 1'b0;
   endtask

   initial begin
      idle();
      instruction_i = '0; instruction_address_i = '0;
      writeback_rd_i = '0; writeback_data_i = '0;
      reset_i = 1'b1;
      step(); step();
      chk("reset_valid", 32'(decode_valid_o), 32'd0);
      chk("reset_pc", pc_o, 32'd0);
      chk("reset_ready", 32'(fetch_ready_o), 32'd1);
      reset_i = 1'b0;

      // addi x1,x0,5
      fetch(32'h00500093, 32'h10);
      step();
      chk("addi_valid", 32'(decode_valid_o), 32'd1);
      chk("addi_pc", pc_o, 32'h10);
      chk("addi_rd", 32'(rd_o), 32'd1);
      chk("addi_rs1", 32'(rs1_o), 32'd0);
      chk("addi_imm", immediate_o, 32'h5);
      chk("addi_class", 32'(class_o), 32'(CLS_OP_IMM));
      chk("addi_alu", 32'(alu_op_o), 32'(ALU_ADD));
      chk("addi_rs1data", rs1_data_o, 32'h0);
      chk("addi_illegal", 32'(illegal_o), 32'd0);

      // add x3,x2,x2 with same-cycle writeback of x2
      fetch(32'h002101B3, 32'h14);
      writeback_enable_i = 1'b1; writeback_rd_i = 5'd2; writeback_data_i = 32'hDEADBEEF;
      step();
      writeback_enable_i = 1'b0;
      chk("byp_rs1data", rs1_data_o, 32'hDEADBEEF);
      chk("byp_rs2data", rs2_data_o, 32'hDEADBEEF);
      chk("byp_alu", 32'(alu_op_o), 32'(ALU_ADD));
      chk("byp_class", 32'(class_o), 32'(CLS_OP));
      chk("byp_rd", 32'(rd_o), 32'd3);

      // add x4,x2,x0 reads x2 from storage
      fetch(32'h00010233, 32'h18);
      step();
      chk("rf_rs1data", rs1_data_o, 32'hDEADBEEF);
      chk("rf_rs2data", rs2_data_o, 32'h0);

      // beq x0,x0,-4 then stall three cycles with a new word pending
      fetch(32'hFE000EE3, 32'h1C);
      step();
      chk("beq_imm", immediate_o, 32'hFFFFFFFC);
      chk("beq_class", 32'(class_o), 32'(CLS_BRANCH));
      fetch(32'h00700293, 32'h20);
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_ready", 32'(fetch_ready_o), 32'd0);
         writeback_enable_i = 1'b1; writeback_rd_i = 5'd0; writeback_data_i = 32'h55;
         step();
         chk("stall_valid", 32'(decode_valid_o), 32'd1);
         chk("stall_pc", pc_o, 32'h1C);
         chk("stall_imm", immediate_o, 32'hFFFFFFFC);
         chk("stall_class", 32'(class_o), 32'(CLS_BRANCH));
      end
      writeback_enable_i = 1'b0;
      stall_i = 1'b0;
      step();
      chk("release_pc", pc_o, 32'h20);
      chk("release_rd", 32'(rd_o), 32'd5);
      chk("release_imm", immediate_o, 32'h7);

      // flush with stall and a pending transfer
      fetch(32'h00100313, 32'h24);
      stall_i = 1'b1; flush_i = 1'b1;
      step();
      chk("flush_valid", 32'(decode_valid_o), 32'd0);
      idle();
      step();
      chk("flush_lost", 32'(decode_valid_o), 32'd0);

      // illegal encodings: all-zero word and bad funct7
      fetch(32'h00000000, 32'h28);
      step();
      chk("zero_valid", 32'(decode_valid_o), 32'd1);
      chk("zero_illegal", 32'(illegal_o), 32'd1);
      chk("zero_class", 32'(class_o), 32'(CLS_ILLEGAL));
      chk("zero_imm", immediate_o, 32'h0);
      fetch(32'h022081B3, 32'h2C);
      step();
      chk("f7_valid", 32'(decode_valid_o), 32'd1);
      chk("f7_illegal", 32'(illegal_o), 32'd1);

      // more formats
      fetch(32'h401101B3, 32'h30);  // sub x3,x2,x1
      step();
      chk("sub_alu", 32'(alu_op_o), 32'(ALU_SUB));
      chk("sub_illegal", 32'(illegal_o), 32'd0);
      fetch(32'h4030D093, 32'h34);  // srai x1,x1,3
      step();
      chk("srai_alu", 32'(alu_op_o), 32'(ALU_SRA));
      chk("srai_imm", immediate_o, 32'h403);
      fetch(32'h123453B7, 32'h38);  // lui x7,0x12345
      step();
      chk("lui_imm", immediate_o, 32'h12345000);
      chk("lui_class", 32'(class_o), 32'(CLS_LUI));
      fetch(32'h0080006F, 32'h3C);  // jal x0,+8
      step();
      chk("jal_imm", immediate_o, 32'h8);
      chk("jal_class", 32'(class_o), 32'(CLS_JAL));
      fetch(32'h00512623, 32'h40);  // sw x5,12(x2)
      step();
      chk("sw_imm", immediate_o, 32'hC);
      chk("sw_class", 32'(class_o), 32'(CLS_STORE));
      chk("sw_rs2", 32'(rs2_o), 32'd5);
      chk("sw_rs1data", rs1_data_o, 32'hDEADBEEF);

      // x0 write is dropped, both as a bypass and as storage
      idle();
      fetch(32'h00000233, 32'h44);  // add x4,x0,x0
      writeback_enable_i = 1'b1; writeback_rd_i = 5'd0; writeback_data_i = 32'h1234;
      step();
      writeback_enable_i = 1'b0;
      chk("x0_byp", rs1_data_o, 32'h0);
      step();
      fetch(32'h00000233, 32'h48);
      step();
      chk("x0_rs1", rs1_data_o, 32'h0);
      chk("x0_rs2", rs2_data_o, 32'h0);

      // reset while a slot is held under stall
      fetch(32'h00500093, 32'h4C);
      step();
      fetch_valid_i = 1'b0;
      stall_i = 1'b1; reset_i = 1'b1;
      step();
      chk("rst_valid", 32'(decode_valid_o), 32'd0);
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_imm", immediate_o, 32'h0);
      chk("rst_rd", 32'(rd_o), 32'd0);
      chk("rst_class", 32'(class_o), 32'd0);
      chk("rst_ready", 32'(fetch_ready_o), 32'd1);
      idle();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/riscv_decode_stage.md
Name: riscv_decode_stage

Overview:
RV32I decode stage that sits directly downstream of the fetch stage. It accepts the instruction word and its address from fetch and reads rs1/rs2 from an integrated 32x32 register file. It decodes fields, immediate and instruction class, then presents the result to execute through one registered pipeline slot with valid/stall/flush control. Writeback writes the register file through this block.

Parameters:
XLEN, 32, data and address width; only 32 is supported.
REG_COUNT, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
clock_i  in  1  single clock; all state updates on the rising edge
reset_i  in  1  synchronous, active-high reset
fetch_valid_i  in  1  instruction_i and instruction_address_i are valid
fetch_ready_o  out  1  decode accepts an instruction this cycle
instruction_i  in  32  fetched instruction word
instruction_address_i  in  32  PC of instruction_i
stall_i  in  1  execute cannot accept the output slot this cycle
flush_i  in  1  redirect; kill the held slot and the incoming instruction
writeback_enable_i  in  1  register-file write strobe
writeback_rd_i  in  5  register-file write index
writeback_data_i  in  32  register-file write data
decode_valid_o  out  1  output slot holds a valid decoded instruction
pc_o  out  32  PC of the decoded instruction
rs1_o, rs2_o, rd_o  out  5 each  register indices
rs1_data_o, rs2_data_o  out  32 each  operand values
immediate_o  out  32  sign-extended immediate per format
funct3_o  out  3  instruction[14:12]
alu_op_o  out  4  ALU operation (package enum)
class_o  out  4  instruction class (package enum)
illegal_o  out  1  unsupported opcode/funct combination

Behaviour:
- Reset: decode_valid_o=0; all other registered outputs are 0. Register file contents are not reset; x0 always reads 0. A reset asserted mid-stall drops the held slot.
- Handshake: fetch_ready_o = !decode_valid_o || !stall_i (combinational). An instruction transfers when fetch_valid_i && fetch_ready_o.
- Latency: 1 cycle. A transfer at edge N appears on the outputs after edge N with decode_valid_o=1.
- No transfer and !stall_i: decode_valid_o <= 0.
- Stall: while decode_valid_o && stall_i, all outputs hold, including rs*_data_o.
- Flush: flush_i has priority over everything except reset. On the next edge decode_valid_o <= 0, regardless of stall or a simultaneous transfer.
- Register file: 2 asynchronous read ports, 1 synchronous write port.
  - Writes with writeback_rd_i=0 are ignored.
  - Bypass: if writeback_enable_i and writeback_rd_i == rs1 (nonzero) in the capture cycle, rs1_data_o takes writeback_data_i. rs2 is handled the same way.
  - Held (stalled) slots are not refreshed by later writes; forwarding of those belongs to the hazard unit.
- Immediates:
  - I = sign(ins[31:20])
  - S = sign({ins[31:25],ins[11:7]})
  - B = sign({ins[31],ins[7],ins[30:25],ins[11:8],0})
  - U = {ins[31:12],12'b0}
  - J = sign({ins[31],ins[19:12],ins[20],ins[30:21],0})
  - Format is selected by opcode. R-type and unknown opcodes give 0.
- Classes by opcode[6:0]: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011, MISC_MEM 0001111, SYSTEM 1110011.
  - Any other opcode, or ins[1:0] != 11, sets illegal_o=1 and class_o=ILLEGAL. The slot is still valid.
- alu_op_o:
  - OP: from funct3 plus funct7[5]. funct7 values other than 0000000/0100000 (ADD/SUB, SRL/SRA only) set illegal_o.
  - OP_IMM: from funct3; SRAI uses ins[30].
  - Every other class produces ADD.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants;
  - class enum (4 bits, including ILLEGAL);
  - alu_op enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND;
  - immediate-format enum;
  - XLEN.
- One sub-module: riscv_register_file (2R1W, x0 hardwired, write-through bypass). The decode logic stays in riscv_decode_stage.

Test Plan:
- addi x1,x0,5 (0x00500093) at PC 0x10, no stall -> next cycle: valid=1, pc_o=0x10, rd=1, rs1=0, immediate=0x5, class=OP_IMM, alu_op=ADD, rs1_data=0.
- Writeback x2=0xDEADBEEF in the same cycle as add x3,x2,x2 (0x002101B3) -> rs1_data=rs2_data=0xDEADBEEF, alu_op=ADD, class=OP.
- beq x0,x0,-4 (0xFE000EE3) -> immediate=0xFFFFFFFC, class=BRANCH. Then stall_i=1 for 3 cycles with new fetch_valid -> fetch_ready_o=0 and outputs unchanged; stall released -> next instruction captured.
- flush_i=1 together with fetch_valid_i=1 and stall_i=1 -> next cycle decode_valid_o=0; the incoming word is lost.
- 0x00000000 and sub with funct7=0x01 (0x022081B3) -> valid=1, illegal_o=1. Writeback to x0 with 0x1234, then read x0 -> 0.
- reset_i=1 while a slot is held under stall -> decode_valid_o=0 and all outputs 0 next cycle; fetch_ready_o=1.
